// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - PE byte stream to 39-bit torus packets, 2-deep buffer, 4-phase req/ack injection
module noc_packet_injector #(
    parameter int         WIDTH   = 39,
    parameter logic [3:0] X_LOCAL = 4'd0,
    parameter logic [3:0] Y_LOCAL = 4'd0,
    parameter logic [3:0] X_MAX   = 4'd2,
    parameter logic [3:0] Y_MAX   = 4'd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic [3:0]       dst_x,
    input  logic [3:0]       dst_y,
    input  logic [1:0]       pkt_type,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack,
    output logic             err_pulse,
    output logic [1:0]       err_code,
    output logic             busy
);

    typedef enum logic [1:0] {A0, A1, A2} asm_state_e;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_e;

    asm_state_e       asm_q, asm_d;
    tx_state_e        tx_q, tx_d;
    logic [9:0]       hdr_q, hdr_d;
    logic [23:0]      pay_q, pay_d;
    logic [1:0]       code_q, code_d;
    logic [4:0]       seq_q, seq_d;
    logic             err_pend_q, err_pend_d;
    logic [1:0]       err_pend_code_q, err_pend_code_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [WIDTH-1:0] fifo_q [2];
    logic [WIDTH-1:0] fifo_d [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ack_meta_q, ack_s_q;

    logic             accept, complete, push, pop;
    logic [1:0]       calc_code, cur_code;
    logic [WIDTH-1:0] pkt;

    assign in_ready  = (count_q < 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_req   = req_q;
    assign out_data  = data_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign busy      = (asm_q != A0) || (count_q != 2'd0) || (tx_q != T_IDLE);

    assign calc_code = ((dst_x > X_MAX) || (dst_y > Y_MAX))         ? 2'b01 :
                       ((dst_x == X_LOCAL) && (dst_y == Y_LOCAL))   ? 2'b10 : 2'b00;
    // The drop decision for a packet is made on its first byte, even when that byte also completes it.
    assign cur_code  = (asm_q == A0) ? calc_code : code_q;

    always_comb begin
        asm_d           = asm_q;
        hdr_d           = hdr_q;
        pay_d           = pay_q;
        code_d          = code_q;
        seq_d           = seq_q;
        err_pend_d      = 1'b0;
        err_pend_code_d = err_pend_code_q;
        err_pulse_d     = err_pend_q;
        err_code_d      = err_pend_q ? err_pend_code_q : err_code_q;
        complete        = 1'b0;
        push            = 1'b0;
        if (accept) begin
            case (asm_q)
                A0: begin
                    hdr_d  = {pkt_type, dst_x, dst_y};
                    pay_d  = {in_data, 16'h0000};
                    code_d = calc_code;
                    asm_d  = in_last ? A0 : A1;
                end
                A1: begin
                    pay_d[15:8] = in_data;
                    asm_d       = in_last ? A0 : A2;
                end
                default: begin
                    pay_d[7:0] = in_data;
                    asm_d      = A0;
                end
            endcase
            complete = in_last || (asm_q == A2);
        end
        pkt = {hdr_d, seq_q, pay_d};
        if (complete) begin
            if (cur_code != 2'b00) begin
                err_pend_d      = 1'b1;
                err_pend_code_d = cur_code;
            end else begin
                push  = 1'b1;
                seq_d = seq_q + 5'd1;
            end
        end
    end

    always_comb begin
        tx_d   = tx_q;
        req_d  = req_q;
        data_d = data_q;
        pop    = 1'b0;
        case (tx_q)
            T_IDLE: begin
                if ((count_q != 2'd0) && !ack_s_q) begin
                    data_d = fifo_q[rd_ptr_q];
                    pop    = 1'b1;
                    req_d  = 1'b1;
                    tx_d   = T_REQ;
                end
            end
            T_REQ: begin
                if (ack_s_q) begin
                    req_d = 1'b0;
                    tx_d  = T_REL;
                end
            end
            T_REL: begin
                if (!ack_s_q) tx_d = T_IDLE;
            end
            default: tx_d = T_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = pkt;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q           <= A0;
            tx_q            <= T_IDLE;
            hdr_q           <= '0;
            pay_q           <= '0;
            code_q          <= '0;
            seq_q           <= '0;
            err_pend_q      <= 1'b0;
            err_pend_code_q <= '0;
            err_pulse_q     <= 1'b0;
            err_code_q      <= '0;
            fifo_q[0]       <= '0;
            fifo_q[1]       <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            req_q           <= 1'b0;
            data_q          <= '0;
            ack_meta_q      <= 1'b0;
            ack_s_q         <= 1'b0;
        end else begin
            asm_q           <= asm_d;
            tx_q            <= tx_d;
            hdr_q           <= hdr_d;
            pay_q           <= pay_d;
            code_q          <= code_d;
            seq_q           <= seq_d;
            err_pend_q      <= err_pend_d;
            err_pend_code_q <= err_pend_code_d;
            err_pulse_q     <= err_pulse_d;
            err_code_q      <= err_code_d;
            fifo_q          <= fifo_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            req_q           <= req_d;
            data_q          <= data_d;
            ack_meta_q      <= out_ack;
            ack_s_q         <= ack_meta_q;
        end
    end

endmodule

// File: doc/noc_packet_injector.md
# noc_packet_injector

Clocked network interface that turns a PE-side byte stream into 39-bit torus NoC packets and injects them into the local switch's input port. It is the transmit end of the switch's packet format:
- type [38:37], dest x [36:33], dest y [32:29], sequence [28:24], payload bytes [23:16], [15:8], [7:0].

It buffers two complete packets and drives the asynchronous local-port channel with a 4-phase bundled-data req/ack handshake. It rejects destinations the switches cannot route.

## Interface
- WIDTH, 39, packet width (fixed format above)
- X_LOCAL, 4'd0, x coordinate of the attached router
- Y_LOCAL, 4'd0, y coordinate of the attached router
- X_MAX, 4'd2, highest legal x coordinate
- Y_MAX, 4'd4, highest legal y coordinate

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  byte offered
- in_ready  out  1  byte accepted when in_valid && in_ready at posedge
- in_data  in  8  payload byte
- in_last  in  1  offered byte ends the packet early
- dst_x  in  4  destination x; sampled with first byte of a packet
- dst_y  in  4  destination y; sampled with first byte
- pkt_type  in  2  packet type; sampled with first byte
- out_req  out  1  4-phase request to local switch input
- out_data  out  WIDTH  packet, bundled with out_req
- out_ack  in  1  4-phase acknowledge; asynchronous to clk
- err_pulse  out  1  one-cycle pulse, packet dropped
- err_code  out  2  01 x/y out of range, 10 destination equals local node; holds until next error
- busy  out  1  assembler mid-packet, FIFO non-empty, or TX not idle

## Operation
Assembler FSM, states A0 → A1 → A2 (bytes already taken):
- **A0 accept:**
  - latch dst_x, dst_y, pkt_type;
  - byte goes to [23:16];
  - compute drop flag: dst_x > X_MAX or dst_y > Y_MAX gives code 01; otherwise dst_x == X_LOCAL && dst_y == Y_LOCAL gives code 10.
- **A1 accept:** byte goes to [15:8].
- **A2 accept:** byte goes to [7:0]; packet complete; return to A0.
- **Early completion:** in_last on an A0 or A1 accept completes the packet with the remaining payload bytes zero. in_last in A2 has no extra effect.

Completion, same posedge as the completing byte:
- Drop flag clear: push {type, x, y, seq, payload} into the 2-entry FIFO, then seq <= seq + 1 (5-bit, 31 wraps to 0).
- Drop flag set: nothing pushed; seq unchanged; err_pulse = 1 on the following cycle; err_code updated.

Flow control and FIFO:
- in_ready = (fifo_count < 2). This is combinational and independent of state. A full FIFO stalls every byte, including non-completing ones.
- A push and a pop in the same cycle leave the count unchanged.

TX FSM, states T_IDLE, T_REQ, T_REL. ack_s is out_ack after a 2-flop synchronizer.
- **T_IDLE:** if the FIFO is non-empty and ack_s == 0: load out_data from the FIFO head, pop, set out_req = 1, go to T_REQ.
- **T_REQ:** when ack_s == 1, set out_req = 0 and go to T_REL. out_data stays unchanged.
- **T_REL:** when ack_s == 0, go to T_IDLE.
- out_data changes only when a new request is loaded.

Reset (asynchronous, any time including mid-handshake):
- Clears to A0, T_IDLE, FIFO empty, seq = 0.
- Outputs: out_req = 0, out_data = 0, err_pulse = 0, err_code = 00, busy = 0, in_ready = 1.
- The in-flight packet and partial packet are lost. The environment must hold out_ack low through reset.

## Timing
- Packet completed at posedge n: out_req rises at posedge n+1 if TX is idle with ack_s low.
- out_ack rises between posedges k-1 and k: ack_s = 1 after posedge k+1, out_req falls at posedge k+2.
- Release: out_ack falls before posedge m: T_IDLE after posedge m+2, next out_req at posedge m+3 at the earliest.
- out_data is stable from the out_req rise until at least the out_req fall. The switch samples on ack.
- err_pulse is high exactly one cycle: posedge n+1 to n+2.
- Back-to-back bytes are accepted every cycle while in_ready = 1. Peak input rate is 1 byte per clk.

## Test plan
- **Basic packet:** X_LOCAL = 0, Y_LOCAL = 1; bytes 0x08, 0x05, 0x0E with dst (1,1), type 01; ack responds 3 cycles after req → out_data = 39'b01_0001_0001_00000_00001000_00000101_00001110, out_req rises 1 cycle after the third byte, seq field 0; the next packet carries seq 1.
- **Early last:** single byte 0xAA with in_last → payload 0xAA0000. Two bytes 0x11, 0x22 with in_last on the second → payload 0x112200.
- **Illegal destinations:**
  - dst (3,0) → err_pulse one cycle, err_code 01, no out_req, seq unchanged.
  - dst (0,1) → err_code 10.
- **Backpressure:** hold out_ack low; stream 9 bytes (3 packets) → first packet on the wire, two in the FIFO, in_ready = 0. Release handshakes → all three are delivered in order with seq 0, 1, 2.
- **Sequence wrap:** 33 legal packets → the 32nd has seq 31, the 33rd has seq 0.
- **Reset mid-handshake:** assert rst_n = 0 with out_req = 1 and one FIFO entry → out_req = 0, busy = 0, in_ready = 1 immediately. After release, a new packet carries seq 0.
